// File: rtl/auth_resp_engine_if.sv
// Authentication response engine front-end: validates a request header, forwards
// supported message types to an external engine, and returns either its reply or an error frame.
module auth_resp_engine_if #(
   parameter int MSG_W        = 1000,
   parameter int RESP_TIMEOUT = 1024,
   parameter int TMO_W        = 16,
   parameter int DROP_W       = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              resp_req_in,
   input  logic [MSG_W-1:0]  auth_msg_resp_in,
   output logic              req_ready_out,
   output logic              eng_req_out,
   output logic [MSG_W-1:0]  eng_msg_out,
   input  logic              eng_ack_in,
   input  logic [MSG_W-1:0]  eng_msg_in,
   output logic              resp_req_out,
   output logic [MSG_W-1:0]  auth_msg_resp_out,
   input  logic              resp_ack_in,
   output logic              timeout_out,
   output logic [DROP_W-1:0] drop_cnt_out
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_CHECK    = 3'd1,
      S_ENG_WAIT = 3'd2,
      S_ERR      = 3'd3,
      S_RESP     = 3'd4
   } state_t;

   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RESP_TIMEOUT - 1);

   state_t              state_q;
   logic [MSG_W-1:0]    req_q;
   logic [MSG_W-1:0]    resp_q;
   logic [7:0]          err_q;
   logic [TMO_W-1:0]    tmo_q;
   logic [DROP_W-1:0]   drop_q;
   logic                ready_q;
   logic                eng_req_q;
   logic                resp_req_q;
   logic                timeout_q;
   logic                drop_hit_d;

   // Error frame: version 0x01, type 0x7F, error code in byte2, rest zero.
   function automatic logic [MSG_W-1:0] err_frame(input logic [7:0] code);
      logic [MSG_W-1:0] frame;
      frame        = '0;
      frame[7:0]   = 8'h01;
      frame[15:8]  = 8'h7F;
      frame[23:16] = code;
      return frame;
   endfunction

   assign drop_hit_d = resp_req_in && (state_q != S_IDLE);

   // Transaction FSM with all outputs registered alongside the state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         req_q      <= '0;
         resp_q     <= '0;
         err_q      <= 8'h00;
         tmo_q      <= '0;
         drop_q     <= '0;
         ready_q    <= 1'b0;
         eng_req_q  <= 1'b0;
         resp_req_q <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         timeout_q <= 1'b0;
         if (drop_hit_d && (drop_q != {DROP_W{1'b1}})) begin
            drop_q <= drop_q + DROP_W'(1);
         end
         case (state_q)
            S_IDLE: begin
               // Ready comes up one edge after reset; requests are taken only once it shows.
               ready_q <= 1'b1;
               if (resp_req_in && ready_q) begin
                  req_q   <= auth_msg_resp_in;
                  ready_q <= 1'b0;
                  state_q <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (req_q[7:0] != 8'h01) begin
                  err_q   <= 8'h02;
                  state_q <= S_ERR;
               end else if (req_q[15:8] inside {8'h81, 8'h82, 8'h83}) begin
                  tmo_q     <= '0;
                  eng_req_q <= 1'b1;
                  state_q   <= S_ENG_WAIT;
               end else begin
                  err_q   <= 8'h01;
                  state_q <= S_ERR;
               end
            end
            S_ENG_WAIT: begin
               if (eng_ack_in) begin
                  resp_q     <= eng_msg_in;
                  eng_req_q  <= 1'b0;
                  resp_req_q <= 1'b1;
                  state_q    <= S_RESP;
               end else if (tmo_q == TMO_LAST) begin
                  timeout_q <= 1'b1;
                  eng_req_q <= 1'b0;
                  err_q     <= 8'h04;
                  state_q   <= S_ERR;
               end else begin
                  tmo_q <= tmo_q + TMO_W'(1);
               end
            end
            S_ERR: begin
               resp_q     <= err_frame(err_q);
               resp_req_q <= 1'b1;
               state_q    <= S_RESP;
            end
            S_RESP: begin
               if (resp_ack_in) begin
                  resp_req_q <= 1'b0;
                  ready_q    <= 1'b1;
                  state_q    <= S_IDLE;
               end
            end
            default: begin
               ready_q    <= 1'b0;
               eng_req_q  <= 1'b0;
               resp_req_q <= 1'b0;
               state_q    <= S_IDLE;
            end
         endcase
      end
   end

   assign req_ready_out     = ready_q;
   assign eng_req_out       = eng_req_q;
   assign eng_msg_out       = req_q;
   assign resp_req_out      = resp_req_q;
   assign auth_msg_resp_out = resp_q;
   assign timeout_out       = timeout_q;
   assign drop_cnt_out      = drop_q;

endmodule

// File: doc/auth_resp_engine_if.md
AUTH_RESP_ENGINE_IF -- requirements
Module: auth_resp_engine_if

Interface
REQ-001 Parameter MSG_W, default 1000, message width in bits; SHALL be at least 32.
REQ-002 Parameter RESP_TIMEOUT, default 1024, maximum cycles spent waiting for the engine; SHALL be at least 2.
REQ-003 Parameter TMO_W, default 16, timeout counter width; SHALL satisfy 2^TMO_W > RESP_TIMEOUT.
REQ-004 Parameter DROP_W, default 8, width of the dropped-request counter.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 resp_req_in  in  1  request strobe; qualifies auth_msg_resp_in.
REQ-008 auth_msg_resp_in  in  MSG_W  request message; byte0 = protocol version, byte1 = message type, LSB-first bytes.
REQ-009 req_ready_out  out  1  high only in IDLE.
REQ-010 eng_req_out  out  1  engine request; level-held until the engine handshake completes.
REQ-011 eng_msg_out  out  MSG_W  captured request presented to the engine.
REQ-012 eng_ack_in  in  1  engine done; qualifies eng_msg_in.
REQ-013 eng_msg_in  in  MSG_W  engine-generated response.
REQ-014 resp_req_out  out  1  response valid; level-held until resp_ack_in.
REQ-015 auth_msg_resp_out  out  MSG_W  response message.
REQ-016 resp_ack_in  in  1  consumer accepts the response.
REQ-017 timeout_out  out  1  one-cycle pulse on engine timeout.
REQ-018 drop_cnt_out  out  DROP_W  count of requests dropped while busy; saturates at all-ones.

Function
REQ-019 The FSM SHALL have the states IDLE, CHECK, ENG_WAIT, ERR and RESP.
REQ-020 IDLE: when resp_req_in=1, capture auth_msg_resp_in into the request register and move to CHECK on the next edge.
REQ-021 CHECK (one cycle): byte0 != 0x01 -> ERR with code 0x02; byte1 in {0x81, 0x82, 0x83} -> ENG_WAIT; any other byte1 -> ERR with code 0x01.
REQ-022 ENG_WAIT: eng_req_out=1 and eng_msg_out=request register; the timeout counter clears on entry and increments each cycle.
REQ-023 ENG_WAIT with eng_ack_in=1: latch eng_msg_in into the response register -> RESP.
REQ-024 ENG_WAIT with the counter at RESP_TIMEOUT-1 and eng_ack_in=0: pulse timeout_out for one cycle -> ERR with code 0x04.
REQ-025 eng_ack_in and the timeout condition in the same cycle: the ack SHALL win, with no timeout pulse.
REQ-026 ERR (one cycle): response register = byte0 0x01, byte1 0x7F, byte2 error code, all other bits 0 -> RESP.
REQ-027 RESP: resp_req_out=1 and auth_msg_resp_out stable; resp_ack_in=1 -> IDLE on the next edge.
REQ-028 resp_ack_in received outside RESP SHALL be ignored; eng_ack_in received outside ENG_WAIT SHALL be ignored.
REQ-029 resp_req_in=1 in any state other than IDLE: the request is discarded, the in-flight transaction is unaffected, and drop_cnt_out increments by 1 unless it is at all-ones.
REQ-030 Minimum latency from the resp_req_in edge to resp_req_out: 3 cycles via ERR; 3 cycles via ENG_WAIT when the engine acks immediately.
REQ-031 A new request SHALL be accepted on the first IDLE cycle after the ack (back-to-back service).

Reset
REQ-032 reset=0 SHALL asynchronously force state IDLE.
REQ-033 Reset SHALL clear the request register, response register, timeout counter and drop_cnt_out to 0.
REQ-034 During reset: resp_req_out, eng_req_out and timeout_out = 0, auth_msg_resp_out = 0, req_ready_out = 0.
REQ-035 req_ready_out SHALL rise on the first clock edge after reset deassertion.
REQ-036 Reset asserted mid-transaction SHALL abandon the transaction, with no response and no timeout pulse.

Verification
REQ-037 Request byte0=0x01, byte1=0x81; engine acks 5 cycles later with 0xABCD -> response 0xABCD; resp_req_out held until resp_ack_in; then IDLE.
REQ-038 Request byte1=0x55 -> response bytes 0x01, 0x7F, 0x01, then zeros; eng_req_out never asserted.
REQ-039 Request byte0=0x02 -> error code 0x02.
REQ-040 Engine never acks, RESP_TIMEOUT=8 -> timeout_out pulses once 8 cycles after ENG_WAIT entry; error code 0x04.
REQ-041 eng_ack_in on the timeout cycle -> engine response delivered and timeout_out stays 0.
REQ-042 Requests issued during ENG_WAIT and RESP, plus 300 drops with DROP_W=8 -> in-flight response unchanged; drop_cnt_out=255.
